load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 57 +++++
 rtl/load_align.sv | 38 +++
 rtl/load_store_unit.sv | 158 +++++++++++++++
 tb/tb_load_store_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 opcodes, access size, FSM states.
// Size and byte-lane helpers are used by both the top and load_align.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        WB   = 2'd3
    } lsu_state_e;

    function automatic lsu_size_e f3_size(input logic [2:0] f3);
        lsu_size_e sz;
        case (f3[1:0])
            2'b00:   sz = SZ_BYTE;
            2'b01:   sz = SZ_HALF;
            default: sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic [3:0] store_be(input lsu_size_e sz, input logic [1:0] lo);
        logic [3:0] be;
        case (sz)
            SZ_BYTE: be = 4'b0001 << lo;
            SZ_HALF: be = 4'b0011 << {lo[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic is_misaligned(input lsu_size_e sz, input logic [1:0] lo);
        logic mis;
        case (sz)
            SZ_HALF: mis = lo[0];
            SZ_WORD: mis = (lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load lane select and sign/zero extension.
module load_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] result_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [31:0] word_s;

    // Pick the addressed byte / halfword lane out of the returned word
    always_comb begin
        case (addr_lo_i)
            2'b00:   byte_s = rdata_i[7:0];
            2'b01:   byte_s = rdata_i[15:8];
            2'b10:   byte_s = rdata_i[23:16];
            default: byte_s = rdata_i[31:24];
        endcase
        half_s = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        word_s = rdata_i[31:0];
    end

    // Extend to XLEN; funct3[2] selects zero-extension
    always_comb begin
        case (f3_size(funct3_i))
            SZ_BYTE: result_o = funct3_i[2] ? XLEN'(byte_s) : XLEN'($signed(byte_s));
            SZ_HALF: result_o = funct3_i[2] ? XLEN'(half_s) : XLEN'($signed(half_s));
            default: result_o = funct3_i[2] ? XLEN'(word_s) : XLEN'($signed(word_s));
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between execute stage, data memory and register file.
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word accesses raise err instead of accessing memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [RA_W-1:0] req_rd,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            wb_we,
    output logic [RA_W-1:0] wb_addr,
    output logic [XLEN-1:0] wb_data,
    output logic            done,
    output logic            err
);

    lsu_state_e      state_q, state_d;
    logic            mem_we_q;
    logic [2:0]      funct3_q;
    logic [1:0]      addr_lo_q;
    logic [RA_W-1:0] rd_q, wb_addr_q;
    logic [XLEN-1:0] mem_addr_q, mem_wdata_q, wb_data_q;
    logic [3:0]      mem_be_q;
    logic            accept_s, trap_s;
    lsu_size_e       req_size_s;
    logic [XLEN-1:0] store_wdata_s, load_res_s;

    assign accept_s   = req_valid && (state_q == IDLE);
    assign req_size_s = f3_size(req_funct3);

`ifdef LSU_MISALIGN_TRAP_EN
    logic err_q;
    assign trap_s = accept_s && is_misaligned(req_size_s, req_addr[1:0]);

    // One-cycle fault pulse following a misaligned accept
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= trap_s;
        end
    end
    assign err = err_q;
`else
    assign trap_s = 1'b0;
    assign err    = 1'b0;
`endif

    // Replicate store data across the lanes the byte enables select
    always_comb begin
        case (req_size_s)
            SZ_BYTE: store_wdata_s = XLEN'({4{req_wdata[7:0]}});
            SZ_HALF: store_wdata_s = XLEN'({2{req_wdata[15:0]}});
            default: store_wdata_s = req_wdata;
        endcase
    end

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata_i   (mem_rdata),
        .addr_lo_i (addr_lo_q),
        .funct3_i  (funct3_q),
        .result_o  (load_res_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; rvalid during the grant cycle is ignored because REQ only looks at gnt
    always_comb begin
        case (state_q)
            IDLE:    state_d = (accept_s && !trap_s) ? REQ : IDLE;
            REQ:     state_d = mem_gnt ? (mem_we_q ? IDLE : WAIT) : REQ;
            WAIT:    state_d = mem_rvalid ? WB : WAIT;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; store completion is flagged in the grant cycle itself
    always_comb begin
        req_ready = 1'b0;
        mem_req   = 1'b0;
        wb_we     = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE:    req_ready = 1'b1;
            REQ: begin
                mem_req = 1'b1;
                done    = mem_we_q && mem_gnt;
            end
            WAIT:    mem_req = 1'b0;
            WB: begin
                wb_we = (rd_q != '0);
                done  = 1'b1;
            end
            default: req_ready = 1'b0;
        endcase
    end

    // Request latch and load writeback registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_we_q    <= 1'b0;
            funct3_q    <= 3'b000;
            addr_lo_q   <= 2'b00;
            rd_q        <= '0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= '0;
            wb_data_q   <= '0;
            wb_addr_q   <= '0;
        end else begin
            if (accept_s) begin
                mem_we_q    <= req_store;
                funct3_q    <= req_funct3;
                addr_lo_q   <= req_addr[1:0];
                rd_q        <= req_rd;
                mem_addr_q  <= {req_addr[XLEN-1:2], 2'b00};
                mem_be_q    <= req_store ? store_be(req_size_s, req_addr[1:0]) : 4'b1111;
                mem_wdata_q <= store_wdata_s;
            end
            if ((state_q == WAIT) && mem_rvalid) begin
                wb_data_q <= load_res_s;
                wb_addr_q <= rd_q;
            end
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_data   = wb_data_q;
    assign wb_addr   = wb_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random transactions
// checked against an arithmetic reference model of the load/store rules.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        wb_we, done, err;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int wb_cnt = 0;

    load_store_unit #(.XLEN(32), .RA_W(5)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wb_we === 1'b1) wb_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain arithmetic on the spec rules
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        case (f3[1:0])
            2'b00: begin
                v = (rd >> ((a % 4) * 8)) & 32'h000000FF;
                if (!f3[2] && v >= 32'h00000080) v = v + 32'hFFFFFF00;
            end
            2'b01: begin
                v = (rd >> (((a / 2) % 2) * 16)) & 32'h0000FFFF;
                if (!f3[2] && v >= 32'h00008000) v = v + 32'hFFFF0000;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v;
        case (f3[1:0])
            2'b00:   v = 32'd1 << (a % 4);
            2'b01:   v = 32'd3 << (((a / 2) % 2) * 2);
            default: v = 32'd15;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] v;
        case (f3[1:0])
            2'b00:   v = (wd % 256) * 32'h01010101;
            2'b01:   v = (wd % 65536) * 32'h00010001;
            default: v = wd;
        endcase
        return v;
    endfunction

    function automatic bit ref_misaligned(input logic [2:0] f3, input logic [31:0] a);
        bit m;
        case (f3[1:0])
            2'b00:   m = 1'b0;
            2'b01:   m = (a % 2) != 0;
            default: m = (a % 4) != 0;
        endcase
        return m;
    endfunction

    task automatic access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rdat, input logic [4:0] rd,
                          input int gd, input int rvd);
        logic [31:0] exp_be, exp_wd, exp_ld;
        int n0;
        exp_be = st ? ref_be(f3, a) : 32'hF;
        exp_wd = ref_wdata(f3, wd);
        exp_ld = ref_load(f3, a, rdat);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
        #1;
        check("ready_idle", req_ready, 1);
        tick();
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
        req_funct3 = 3'($urandom); req_store = 1'($urandom);
        n0 = wb_cnt;
`ifdef LSU_MISALIGN_TRAP_EN
        if (ref_misaligned(f3, a)) begin
            check("trap_err", err, 1);
            check("trap_no_req", mem_req, 0);
            check("trap_no_done", done, 0);
            tick();
            check("trap_err_clear", err, 0);
            check("trap_ready", req_ready, 1);
            check("trap_no_req2", mem_req, 0);
            check("trap_no_wb", wb_cnt - n0, 0);
            return;
        end
`endif
        for (int i = 0; i < gd; i++) begin
            check("req_hold", mem_req, 1);
            check("req_busy", req_ready, 0);
            check("req_addr_stable", mem_addr, a & 32'hFFFFFFFC);
            check("req_be_stable", mem_be, exp_be);
            check("req_we_stable", mem_we, st);
            if (st) check("req_wdata_stable", mem_wdata, exp_wd);
            check("no_done_wait_gnt", done, 0);
            tick();
        end
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = ~rdat;
        #1;
        check("gnt_req", mem_req, 1);
        check("gnt_we", mem_we, st);
        check("gnt_addr", mem_addr, a & 32'hFFFFFFFC);
        check("gnt_be", mem_be, exp_be);
        if (st) check("gnt_wdata", mem_wdata, exp_wd);
        check("gnt_done", done, st);
        check("gnt_err", err, 0);
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        if (st) begin
            check("st_done_end", done, 0);
            check("st_ready", req_ready, 1);
            check("st_req_end", mem_req, 0);
            check("st_no_wb", wb_cnt - n0, 0);
            return;
        end
        for (int i = 0; i < rvd; i++) begin
            check("wait_no_req", mem_req, 0);
            check("wait_no_wb", wb_we, 0);
            check("wait_busy", req_ready, 0);
            tick();
        end
        mem_rvalid = 1'b1; mem_rdata = rdat;
        #1;
        check("rv_no_wb", wb_we, 0);
        tick();
        mem_rvalid = 1'b0; mem_rdata = $urandom;
        check("wb_we", wb_we, (rd != 5'd0));
        check("wb_addr", wb_addr, rd);
        check("wb_data", wb_data, exp_ld);
        check("wb_done", done, 1);
        check("wb_busy", req_ready, 0);
        tick();
        check("post_wb_we", wb_we, 0);
        check("post_done", done, 0);
        check("post_wb_data", wb_data, exp_ld);
        check("post_wb_addr", wb_addr, rd);
        check("post_ready", req_ready, 1);
        check("wb_count", wb_cnt - n0, (rd != 5'd0));
    endtask

    initial begin
        int n0;
        reset_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        #2;
        check("rst_ready", req_ready, 1);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_be", mem_be, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_wb_we", wb_we, 0);
        check("rst_wb_addr", wb_addr, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 5'd1, 0, 0);            // SW
        access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80AABBCC, 5'd5, 0, 0);            // LB
        access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80AABBCC, 5'd5, 0, 0);            // LBU
        access(1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 5'd2, 0, 0);            // SH
        access(1'b0, 3'b010, 32'h200, 32'h0, 32'h11223344, 5'd7, 3, 2);            // LW slow
        access(1'b0, 3'b001, 32'h101, 32'h0, 32'hCAFE8001, 5'd9, 0, 0);            // LH misaligned
        access(1'b0, 3'b101, 32'h106, 32'h0, 32'h9ABC0000, 5'd0, 1, 1);            // LHU rd=0
        access(1'b1, 3'b000, 32'h041, 32'h000000A5, 32'h0, 5'd3, 2, 0);            // SB

        // Reset while a load waits for rvalid
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h300; req_rd = 5'd3;
        tick();
        req_valid = 1'b0; mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        n0 = wb_cnt;
        reset_n = 1'b0;
        #1;
        check("mrst_ready", req_ready, 1);
        check("mrst_mem_req", mem_req, 0);
        check("mrst_wb_data", wb_data, 0);
        check("mrst_mem_addr", mem_addr, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h55;
        tick();
        mem_rvalid = 1'b0;
        tick();
        check("mrst_no_wb", wb_cnt - n0, 0);
        check("mrst_ready_after", req_ready, 1);
        check("mrst_wb_data_after", wb_data, 0);
        check("mrst_done", done, 0);

        for (int k = 0; k < 40; k++) begin
            access(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom, 5'($urandom),
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
